// File: rtl/mtimer_pkg.sv
// Shared constants for the machine timer: register window layout, control bits
// and the interrupt cause code the CSR unit reports for a timer interrupt.
package mtimer_pkg;

    localparam logic [31:0] MTIME_LO    = 32'h0000_0000;
    localparam logic [31:0] MTIME_HI    = 32'h0000_0004;
    localparam logic [31:0] MTIMECMP_LO = 32'h0000_0008;
    localparam logic [31:0] MTIMECMP_HI = 32'h0000_000C;
    localparam logic [31:0] CTRL        = 32'h0000_0010;
    localparam logic [31:0] STATUS      = 32'h0000_0014;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] MTI_CAUSE    = 32'h8000_0007;

    localparam int PRESC_W = 16;

    // Byte address to word-aligned register offset.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/mtimer_prescale.sv
// Tick generator: one tick every PRESCALE enabled cycles; clr restarts the count.
module mtimer_prescale
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0] cnt_r;

    assign tick = en & (cnt_r == LAST);

    // Prescale counter: holds while disabled, wraps after LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {PRESC_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {PRESC_W{1'b0}};
        end else if (en) begin
            cnt_r <= (cnt_r == LAST) ? {PRESC_W{1'b0}} : cnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp on a 32-bit word bus, active-low
// registered interrupt ti while mtime >= mtimecmp and the timer is enabled.
module mtimer
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic              bus_re,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_rvalid,
    output logic              ti
);

    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic        en_r;
    logic        cmp_hold_r;
    logic [31:0] shadow_r;
    logic [31:0] rdata_r;
    logic        rvalid_r;
    logic        ti_r;

    logic [31:0] addr_s;
    logic        wr_s;
    logic        rd_s;
    logic        wr_mlo_s;
    logic        wr_mhi_s;
    logic        wr_clo_s;
    logic        wr_chi_s;
    logic        wr_ctrl_s;
    logic        clr_pend_s;
    logic        tick_s;
    logic        cmp_s;
    logic [31:0] rdata_s;

    assign addr_s     = word_addr(32'(bus_addr));
    assign wr_s       = ~bus_sel & ~bus_we;
    assign rd_s       = ~bus_sel & ~bus_re;
    assign clr_pend_s = wr_ctrl_s & bus_wdata[CTRL_CLR];
    // cmp_hold masks the compare between the two halves of an mtimecmp update.
    assign cmp_s      = ~cmp_hold_r & (mtime_r >= mtimecmp_r);

    mtimer_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_r),
        .clr   (wr_mlo_s | wr_mhi_s),
        .tick  (tick_s)
    );

    // Write strobe decode per register.
    always_comb begin
        wr_mlo_s  = 1'b0;
        wr_mhi_s  = 1'b0;
        wr_clo_s  = 1'b0;
        wr_chi_s  = 1'b0;
        wr_ctrl_s = 1'b0;
        if (wr_s) begin
            case (addr_s)
                MTIME_LO:    wr_mlo_s  = 1'b1;
                MTIME_HI:    wr_mhi_s  = 1'b1;
                MTIMECMP_LO: wr_clo_s  = 1'b1;
                MTIMECMP_HI: wr_chi_s  = 1'b1;
                CTRL:        wr_ctrl_s = 1'b1;
                default:     wr_ctrl_s = 1'b0;
            endcase
        end else begin
            wr_ctrl_s = 1'b0;
        end
    end

    // Read mux; mtime_hi returns the shadow captured by the last mtime_lo read.
    always_comb begin
        rdata_s = 32'd0;
        case (addr_s)
            MTIME_LO:    rdata_s = mtime_r[31:0];
            MTIME_HI:    rdata_s = shadow_r;
            MTIMECMP_LO: rdata_s = mtimecmp_r[31:0];
            MTIMECMP_HI: rdata_s = mtimecmp_r[63:32];
            CTRL:        rdata_s = {31'd0, en_r};
            STATUS:      rdata_s = {31'd0, cmp_s};
            default:     rdata_s = 32'd0;
        endcase
    end

    // mtime: a bus write beats a tick in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_r <= 64'd0;
        end else if (wr_mlo_s) begin
            mtime_r[31:0] <= bus_wdata;
        end else if (wr_mhi_s) begin
            mtime_r[63:32] <= bus_wdata;
        end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
        end else begin
            mtime_r <= mtime_r;
        end
    end

    // mtimecmp, compare hold flag and enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp_r <= MTIMECMP_RST;
            cmp_hold_r <= 1'b0;
            en_r       <= 1'b0;
        end else begin
            if (wr_clo_s) begin
                mtimecmp_r[31:0] <= bus_wdata;
                cmp_hold_r       <= 1'b1;
            end else if (wr_chi_s) begin
                mtimecmp_r[63:32] <= bus_wdata;
                cmp_hold_r        <= 1'b0;
            end else begin
                mtimecmp_r <= mtimecmp_r;
                cmp_hold_r <= cmp_hold_r;
            end
            if (wr_ctrl_s) begin
                en_r <= bus_wdata[CTRL_EN];
            end else begin
                en_r <= en_r;
            end
        end
    end

    // Read response register and hi-shadow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r  <= 32'd0;
            rvalid_r <= 1'b0;
            shadow_r <= 32'd0;
        end else begin
            rvalid_r <= rd_s;
            if (rd_s) begin
                rdata_r <= rdata_s;
            end else begin
                rdata_r <= rdata_r;
            end
            if (rd_s && (addr_s == MTIME_LO)) begin
                shadow_r <= mtime_r[63:32];
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    // Interrupt level; CLR_PEND releases it for one cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ti_r <= 1'b1;
        end else if (clr_pend_s) begin
            ti_r <= 1'b1;
        end else begin
            ti_r <= ~(cmp_s & en_r);
        end
    end

    assign bus_rdata  = rdata_r;
    assign bus_rvalid = rvalid_r;
    assign ti         = ti_r;

endmodule

// File: tb/tb_mtimer.sv
// Scoreboard bench: two timers (PRESCALE 1 and 4) share one bus; a reference
// model predicts read data and ti, a monitor compares at every falling edge.
module tb_mtimer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_sel, bus_we, bus_re;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic        ti0, ti1;

    always #5 clk = ~clk;

    mtimer #(.PRESCALE(1), .ADDR_W(5)) u_p1 (
        .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .bus_we(bus_we), .bus_re(bus_re),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata0),
        .bus_rvalid(rvalid0), .ti(ti0)
    );

    mtimer #(.PRESCALE(4), .ADDR_W(5)) u_p4 (
        .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .bus_we(bus_we), .bus_re(bus_re),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata1),
        .bus_rvalid(rvalid1), .ti(ti1)
    );

    // Reference model state, one slot per timer instance.
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic        m_en   [2];
    logic        m_hold [2];
    logic [31:0] m_shad [2];
    int          m_cnt  [2];
    logic        exp_ti [2];
    int          presc  [2] = '{1, 4};
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;
    logic final_chk = 1'b0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_time[d] = 64'd0;
            m_cmp[d]  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_en[d]   = 1'b0;
            m_hold[d] = 1'b0;
            m_shad[d] = 32'd0;
            m_cnt[d]  = 0;
            exp_ti[d] = 1'b1;
        end
        q0.delete();
        q1.delete();
    endtask

    // Apply one clock edge of architectural behaviour to the model.
    task automatic model_edge(input logic use_fv, input logic [31:0] fv);
        logic        wr, rd, cmpv, tk;
        logic [31:0] a, rv;
        wr = !bus_sel && !bus_we;
        rd = !bus_sel && !bus_re;
        a  = {27'd0, bus_addr} & 32'hFFFF_FFFC;
        for (int d = 0; d < 2; d++) begin
            cmpv = !m_hold[d] && (m_time[d] >= m_cmp[d]);
            tk   = m_en[d] && (m_cnt[d] == presc[d] - 1);
            if (rd) begin
                case (a)
                    32'h00:  rv = m_time[d][31:0];
                    32'h04:  rv = m_shad[d];
                    32'h08:  rv = m_cmp[d][31:0];
                    32'h0C:  rv = m_cmp[d][63:32];
                    32'h10:  rv = {31'd0, m_en[d]};
                    32'h14:  rv = {31'd0, cmpv};
                    default: rv = 32'd0;
                endcase
                if (a == 32'h00) m_shad[d] = m_time[d][63:32];
                if (d == 0 && use_fv) rv = fv;
                if (d == 0) q0.push_back(rv);
                else        q1.push_back(rv);
            end
            exp_ti[d] = (wr && a == 32'h10 && bus_wdata[1]) ? 1'b1 : !(cmpv && m_en[d]);
            if (wr && a == 32'h00)      m_time[d][31:0]  = bus_wdata;
            else if (wr && a == 32'h04) m_time[d][63:32] = bus_wdata;
            else if (tk)                m_time[d]        = m_time[d] + 64'd1;
            if (wr && (a == 32'h00 || a == 32'h04)) m_cnt[d] = 0;
            else if (m_en[d]) m_cnt[d] = (m_cnt[d] == presc[d] - 1) ? 0 : m_cnt[d] + 1;
            if (wr && a == 32'h08) begin m_cmp[d][31:0]  = bus_wdata; m_hold[d] = 1'b1; end
            if (wr && a == 32'h0C) begin m_cmp[d][63:32] = bus_wdata; m_hold[d] = 1'b0; end
            if (wr && a == 32'h10) m_en[d] = bus_wdata[0];
        end
    endtask

    task automatic step(input logic s, input logic w, input logic r, input logic [4:0] a,
                        input logic [31:0] wd, input logic use_fv, input logic [31:0] fv);
        bus_sel = s; bus_we = w; bus_re = r; bus_addr = a; bus_wdata = wd;
        @(posedge clk);
        model_edge(use_fv, fv);
        #1;
        bus_sel = 1'b1; bus_we = 1'b1; bus_re = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 1'b1, a, d, 1'b0, 32'd0);
    endtask

    task automatic rd_exp(input logic [4:0] a, input logic [31:0] v);
        step(1'b0, 1'b1, 1'b0, a, 32'd0, 1'b1, v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    // Monitor: ti every cycle, read responses popped from the scoreboard queues.
    always @(negedge clk) begin
        logic [31:0] e;
        chk("ti_p1", {63'd0, ti0}, {63'd0, exp_ti[0]});
        chk("ti_p4", {63'd0, ti1}, {63'd0, exp_ti[1]});
        if (rvalid0) begin
            if (q0.size() == 0) chk("rvalid_p1_unexpected", 64'd1, 64'd0);
            else begin e = q0.pop_front(); chk("rdata_p1", {32'd0, rdata0}, {32'd0, e}); end
        end else if (q0.size() != 0) begin
            chk("rvalid_p1_missing", 64'd0, 64'd1);
            void'(q0.pop_front());
        end
        if (rvalid1) begin
            if (q1.size() == 0) chk("rvalid_p4_unexpected", 64'd1, 64'd0);
            else begin e = q1.pop_front(); chk("rdata_p4", {32'd0, rdata1}, {32'd0, e}); end
        end else if (q1.size() != 0) begin
            chk("rvalid_p4_missing", 64'd0, 64'd1);
            void'(q1.pop_front());
        end
        if (done && !final_chk) begin
            final_chk = 1'b1;
            chk("leftover_q", 64'(q0.size() + q1.size()), 64'd0);
        end
    end

    initial begin
        logic [4:0]  ra;
        logic [31:0] rwd;
        logic        rs, rw, rr;
        bus_sel = 1'b1; bus_we = 1'b1; bus_re = 1'b1; bus_addr = 5'd0; bus_wdata = 32'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset values.
        rd_exp(5'h0C, 32'hFFFF_FFFF);
        rd_exp(5'h10, 32'd0);
        rd_exp(5'h00, 32'd0);
        rd_exp(5'h18, 32'd0);

        // Basic compare at mtime 5, then move mtimecmp above mtime.
        wr(5'h08, 32'd5);
        wr(5'h0C, 32'd0);
        wr(5'h10, 32'd1);
        idle(10);
        wr(5'h08, 32'd100);
        idle(3);
        wr(5'h0C, 32'd0);

        // Carry into mtime_hi and coherent lo/hi read.
        wr(5'h10, 32'd0);
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h04, 32'd0);
        wr(5'h10, 32'd1);
        idle(1);
        rd_exp(5'h00, 32'hFFFF_FFFF);
        rd_exp(5'h04, 32'd0);
        wr(5'h10, 32'd0);
        rd_exp(5'h00, 32'd2);
        rd_exp(5'h04, 32'd1);

        // Split mtimecmp write with mtime already past the new compare value.
        wr(5'h04, 32'd0);
        wr(5'h00, 32'h10);
        wr(5'h10, 32'd1);
        wr(5'h08, 32'h8);
        idle(4);
        wr(5'h0C, 32'd0);
        idle(3);

        // CLR_PEND while pending: one-cycle release then re-assert.
        wr(5'h10, 32'd3);
        idle(3);

        // Write to mtime_lo in a tick cycle wins over the increment.
        wr(5'h00, 32'h100);
        rd_exp(5'h00, 32'h101 - 32'd1);

        // Freeze with EN=0, then watch the PRESCALE=4 instance advance.
        wr(5'h10, 32'd0);
        idle(5);
        step(1'b0, 1'b1, 1'b0, 5'h00, 32'd0, 1'b0, 32'd0);
        wr(5'h10, 32'd1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 5'h00, 32'd0, 1'b0, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ra = 5'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            rs = ($urandom_range(0, 9) == 0);
            rw = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 1) != 0);
            case (ra & 5'h1C)
                5'h00, 5'h08: rwd = 32'($urandom_range(0, 300));
                5'h04, 5'h0C: rwd = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
                5'h10:        rwd = 32'($urandom_range(0, 3)) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
                default:      rwd = $urandom;
            endcase
            step(rs, rw, rr, ra, rwd, 1'b0, 32'd0);
        end

        // Asynchronous reset while the interrupt is asserted.
        wr(5'h00, 32'h50);
        wr(5'h04, 32'd0);
        wr(5'h08, 32'h10);
        wr(5'h0C, 32'd0);
        wr(5'h10, 32'd1);
        idle(3);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        rd_exp(5'h0C, 32'hFFFF_FFFF);
        idle(2);
        done = 1'b1;
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
